// File: rtl/instr_fetch.sv
// Instruction fetch unit: samples the PC on a fetch strobe, performs one word read
// over a req/ready + rvalid bus, and reports the instruction or a fetch fault.
module instr_fetch #(
    parameter int unsigned    ADDR_W      = 32,
    parameter int unsigned    DATA_W      = 32,
    parameter int unsigned    TIMEOUT     = 16,
    parameter logic [DATA_W-1:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Fetch,
    input  logic [ADDR_W-1:0] i_PC,
    output logic              o_MemReq,
    output logic [ADDR_W-1:0] o_MemAddr,
    input  logic              i_MemReady,
    input  logic              i_MemRValid,
    input  logic [DATA_W-1:0] i_MemRData,
    output logic [DATA_W-1:0] o_Instr,
    output logic              o_InstrValid,
    output logic              o_Busy,
    output logic              o_Fault,
    output logic              o_FaultCause
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                memreq_q, memreq_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                ivalid_q, ivalid_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;
    logic                cause_q, cause_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_hit;

    // Terminal count only matters when no handshake arrives; handshake is checked first.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_q  <= IDLE;
            memreq_q <= 1'b0;
            addr_q   <= '0;
            instr_q  <= RESET_INSTR;
            ivalid_q <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            cause_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            memreq_q <= memreq_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        memreq_d = memreq_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        ivalid_d = 1'b0;
        busy_d   = busy_q;
        fault_d  = 1'b0;
        cause_d  = cause_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (i_Fetch) begin
                    if (i_PC[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        cause_d = 1'b0;
                    end else begin
                        addr_d   = i_PC;
                        memreq_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (memreq_q && i_MemReady) begin
                    memreq_d = 1'b0;
                    if (i_MemRValid) begin
                        instr_d = i_MemRData;
                        state_d = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end
                end else if (timeout_hit) begin
                    memreq_d = 1'b0;
                    fault_d  = 1'b1;
                    cause_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (i_MemRValid) begin
                    instr_d = i_MemRData;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    cause_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ivalid_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_MemReq     = memreq_q;
    assign o_MemAddr    = addr_q;
    assign o_Instr      = instr_q;
    assign o_InstrValid = ivalid_q;
    assign o_Busy       = busy_q;
    assign o_Fault      = fault_q;
    assign o_FaultCause = cause_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, zero-wait, wait-state, misaligned,
// timeout, terminal-cycle handshake, ignored strobe and reset mid-fetch.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        fetch;
    logic [31:0] pc;
    logic        memreq;
    logic [31:0] memaddr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic        ivalid;
    logic        busy;
    logic        fault;
    logic        cause;

    int errors = 0;
    int checks = 0;

    instr_fetch #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT     (16),
        .RESET_INSTR (32'h0000_0013)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Fetch      (fetch),
        .i_PC         (pc),
        .o_MemReq     (memreq),
        .o_MemAddr    (memaddr),
        .i_MemReady   (ready),
        .i_MemRValid  (rvalid),
        .i_MemRData   (rdata),
        .o_Instr      (instr),
        .o_InstrValid (ivalid),
        .o_Busy       (busy),
        .o_Fault      (fault),
        .o_FaultCause (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; fetch = 1'b0; pc = '0; ready = 1'b0; rvalid = 1'b0; rdata = '0;

        // Reset
        tick(); tick(); tick();
        check("rst_instr",  instr,   32'h13);
        check("rst_memreq", {31'b0, memreq}, 32'd0);
        check("rst_addr",   memaddr, 32'd0);
        check("rst_busy",   {31'b0, busy},   32'd0);
        check("rst_ivalid", {31'b0, ivalid}, 32'd0);
        check("rst_fault",  {31'b0, fault},  32'd0);
        check("rst_cause",  {31'b0, cause},  32'd0);
        rst = 1'b1;
        tick();

        // Zero-wait fetch
        pc = 32'h100; fetch = 1'b1; ready = 1'b1; rvalid = 1'b1; rdata = 32'h00500093;
        tick();
        check("zw_req",   {31'b0, memreq}, 32'd1);
        check("zw_addr",  memaddr, 32'h100);
        check("zw_busy",  {31'b0, busy},   32'd1);
        fetch = 1'b0;
        tick();
        check("zw_req_drop", {31'b0, memreq}, 32'd0);
        check("zw_instr",    instr, 32'h00500093);
        check("zw_ivalid_early", {31'b0, ivalid}, 32'd0);
        ready = 1'b0; rvalid = 1'b0; rdata = '0;
        tick();
        check("zw_ivalid", {31'b0, ivalid}, 32'd1);
        check("zw_busy_clr", {31'b0, busy}, 32'd0);
        check("zw_fault", {31'b0, fault}, 32'd0);
        tick();
        check("zw_ivalid_pulse", {31'b0, ivalid}, 32'd0);

        // Wait states on ready, then delayed rvalid
        pc = 32'h104; fetch = 1'b1;
        tick();
        check("ws_req", {31'b0, memreq}, 32'd1);
        fetch = 1'b0; pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_req_hold",  {31'b0, memreq}, 32'd1);
            check("ws_addr_hold", memaddr, 32'h104);
        end
        ready = 1'b1;
        tick();
        check("ws_req_drop", {31'b0, memreq}, 32'd0);
        check("ws_busy", {31'b0, busy}, 32'd1);
        ready = 1'b0; rdata = 32'hDEADBEEF;
        tick();
        check("ws_no_ivalid", {31'b0, ivalid}, 32'd0);
        check("ws_ignore_data", instr, 32'h00500093);
        rvalid = 1'b1; rdata = 32'hFE000EE3;
        tick();
        check("ws_instr", instr, 32'hFE000EE3);
        rvalid = 1'b0; rdata = '0;
        tick();
        check("ws_ivalid", {31'b0, ivalid}, 32'd1);
        tick();
        check("ws_ivalid_pulse", {31'b0, ivalid}, 32'd0);

        // Misaligned PC
        pc = 32'h102; fetch = 1'b1;
        tick();
        check("mis_fault", {31'b0, fault},  32'd1);
        check("mis_cause", {31'b0, cause},  32'd0);
        check("mis_req",   {31'b0, memreq}, 32'd0);
        check("mis_busy",  {31'b0, busy},   32'd0);
        fetch = 1'b0;
        tick();
        check("mis_fault_pulse", {31'b0, fault}, 32'd0);
        check("mis_req2", {31'b0, memreq}, 32'd0);
        check("mis_instr", instr, 32'hFE000EE3);

        // Timeout in REQ: fault 16 cycles after REQ entry
        pc = 32'h200; fetch = 1'b1;
        tick();
        check("to_req", {31'b0, memreq}, 32'd1);
        fetch = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_wait_req",   {31'b0, memreq}, 32'd1);
            check("to_wait_fault", {31'b0, fault},  32'd0);
            check("to_wait_ivalid", {31'b0, ivalid}, 32'd0);
        end
        tick();
        check("to_req_drop", {31'b0, memreq}, 32'd0);
        check("to_fault", {31'b0, fault}, 32'd1);
        check("to_cause", {31'b0, cause}, 32'd1);
        check("to_busy",  {31'b0, busy},  32'd0);
        check("to_ivalid", {31'b0, ivalid}, 32'd0);
        tick();
        check("to_fault_pulse", {31'b0, fault}, 32'd0);
        check("to_cause_hold",  {31'b0, cause}, 32'd1);
        check("to_instr", instr, 32'hFE000EE3);

        // Handshake on the terminal cycle beats timeout
        pc = 32'h400; fetch = 1'b1;
        tick();
        fetch = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        check("term_req_still", {31'b0, memreq}, 32'd1);
        ready = 1'b1; rvalid = 1'b1; rdata = 32'hAAAA5555;
        tick();
        check("term_fault", {31'b0, fault}, 32'd0);
        check("term_instr", instr, 32'hAAAA5555);
        ready = 1'b0; rvalid = 1'b0; rdata = '0;
        tick();
        check("term_ivalid", {31'b0, ivalid}, 32'd1);
        check("term_fault2", {31'b0, fault},  32'd0);
        tick();

        // Ignored strobe in RESP, then reset mid-fetch
        pc = 32'h300; fetch = 1'b1;
        tick();
        check("rm_req", {31'b0, memreq}, 32'd1);
        fetch = 1'b0; ready = 1'b1;
        tick();
        check("rm_req_drop", {31'b0, memreq}, 32'd0);
        ready = 1'b0; fetch = 1'b1;
        tick();
        check("rm_strobe_ign", {31'b0, memreq}, 32'd0);
        check("rm_busy", {31'b0, busy}, 32'd1);
        fetch = 1'b0;
        tick();
        check("rm_no_queue", {31'b0, memreq}, 32'd0);
        rst = 1'b0;
        tick();
        check("rm_rst_busy",  {31'b0, busy}, 32'd0);
        check("rm_rst_instr", instr, 32'h13);
        rst = 1'b1; rvalid = 1'b1; rdata = 32'h12345678;
        tick();
        check("rm_late_ivalid", {31'b0, ivalid}, 32'd0);
        check("rm_late_instr",  instr, 32'h13);
        rvalid = 1'b0; rdata = '0;
        tick();
        check("rm_idle_ivalid", {31'b0, ivalid}, 32'd0);
        check("rm_idle_busy",   {31'b0, busy},   32'd0);
        check("rm_idle_instr",  instr, 32'h13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the PC interface in the MultiCycleV1 CPU.
- On a fetch strobe from the control FSM, it samples the PC and issues a word read on the instruction memory bus using a request/ready then response-valid protocol.
- It captures the returned instruction word and presents it to decode with a one-cycle valid pulse.
- It flags misaligned PCs and memory timeouts as fetch faults.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- TIMEOUT, 16, max cycles waiting in request or response phase before fault; 0 disables timeout.
- RESET_INSTR, 32'h0000_0013, value of o_Instr after reset (NOP).

Ports:
- i_Clk  in  1  clock; all logic on rising edge.
- i_Rst  in  1  synchronous reset, active-low (0 = reset).
- i_Fetch  in  1  start-fetch strobe from control FSM; sampled only in IDLE.
- i_PC  in  ADDR_W  current PC from PC logic.
- o_MemReq  out  1  read request valid.
- o_MemAddr  out  ADDR_W  read address, word aligned.
- i_MemReady  in  1  memory accepts request when o_MemReq & i_MemReady.
- i_MemRValid  in  1  read data valid.
- i_MemRData  in  DATA_W  read data.
- o_Instr  out  DATA_W  last fetched instruction, held until the next successful fetch.
- o_InstrValid  out  1  one-cycle pulse: o_Instr updated.
- o_Busy  out  1  fetch in progress (state != IDLE).
- o_Fault  out  1  one-cycle pulse: misaligned PC or timeout.
- o_FaultCause  out  1  0 = misaligned, 1 = timeout; valid with o_Fault, holds otherwise.

Behaviour:
- All outputs registered.
- Reset values (i_Rst=0 at a clock edge):
  - state=IDLE
  - o_MemReq=0, o_MemAddr=0
  - o_Instr=RESET_INSTR
  - o_InstrValid=0, o_Busy=0, o_Fault=0, o_FaultCause=0
  - timeout counter=0
- Reset mid-operation aborts immediately. A late i_MemRValid after reset is ignored because the FSM is in IDLE.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If i_Fetch=1 and i_PC[1:0]!=0: o_Fault=1 and o_FaultCause=0 next cycle; stay IDLE; no request issued.
  - If i_Fetch=1 and aligned: o_MemAddr<=i_PC, o_MemReq<=1, o_Busy<=1, counter cleared, go to REQ.
- REQ:
  - o_MemReq and o_MemAddr held stable until the handshake.
  - On o_MemReq&i_MemReady:
    - o_MemReq<=0.
    - If i_MemRValid=1 in the same cycle, capture i_MemRData into o_Instr and go to DONE.
    - Otherwise clear counter and go to RESP.
- RESP: on i_MemRValid, capture i_MemRData into o_Instr and go to DONE. i_MemRData is ignored when i_MemRValid=0.
- DONE: o_InstrValid=1 for exactly this cycle; o_Busy=0 on the following cycle; return to IDLE.
- Minimum latency: i_Fetch at edge N -> o_MemReq high after N. With ready and rvalid both high at edge N+1, o_InstrValid is high after N+2. A new fetch can be accepted from edge N+3.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle in REQ or RESP without the awaited handshake.
  - When it reaches TIMEOUT-1 and the handshake is still absent: o_MemReq<=0, o_Fault=1, o_FaultCause=1, go to IDLE.
  - o_Instr is unchanged and o_InstrValid is not pulsed.
  - A handshake on the terminal cycle wins over timeout.
- i_Fetch outside IDLE is ignored; it is not queued.
- i_PC changes after acceptance do not affect o_MemAddr.
- o_Fault and o_InstrValid are never high together.

Test Plan:
- Reset: hold i_Rst=0 for 3 clocks -> o_Instr=32'h13; o_MemReq, o_Busy, o_InstrValid, o_Fault all 0.
- Zero-wait fetch: i_PC=32'h100, pulse i_Fetch; ready=1 and rvalid=1 with data 32'h00500093 in the request cycle -> o_MemAddr=32'h100, o_InstrValid pulses 2 cycles after i_Fetch, o_Instr=32'h00500093.
- Wait states: i_PC=32'h104; ready low for 3 cycles, then high; rvalid arrives 2 cycles later with 32'hFE000EE3 -> o_MemReq/o_MemAddr stable while stalled, one o_InstrValid pulse, o_Instr=32'hFE000EE3.
- Misaligned: i_PC=32'h102, pulse i_Fetch -> o_Fault=1, o_FaultCause=0 for one cycle; o_MemReq never asserted; o_Instr unchanged.
- Timeout: TIMEOUT=16, i_PC=32'h200, ready held 0 -> o_MemReq deasserts and o_Fault=1, o_FaultCause=1 exactly 16 cycles after REQ entry; o_InstrValid never pulses.
- Reset mid-fetch and ignored strobe: i_Fetch pulsed again while in RESP -> no second request. Assert i_Rst=0 in RESP, then deliver rvalid after reset release -> state IDLE, o_Instr=32'h13, no o_InstrValid.
